store_buffer: RTL
=================

# store_buffer

Store-side counterpart of the load data-extension path. It accepts SB/SH/SW requests from the MEM stage, converts each into a word-aligned address, lane-replicated write data and a 4-bit byte-write-enable, and queues them in a small FIFO. The FIFO drains to Data Memory over a req/ack handshake. It also flags misaligned stores and reports when a load hits a pending store, so the hazard unit can stall that load.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16
- CNT_W, $clog2(DEPTH)+1, width of occupancy counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  MEM stage presents a store this cycle
- st_type  in  2  01 SB, 10 SH, 11 SW, 00 none (treated as no request)
- st_addr  in  32  byte address of store
- st_data  in  32  register rs2 value; low byte/half used for SB/SH
- st_ready  out  1  buffer can accept; equals (count < DEPTH)
- misalign  out  1  registered one-cycle pulse: previous accepted-cycle store was misaligned and dropped
- mem_req  out  1  head entry valid, write requested
- mem_addr  out  32  {head_addr[31:2], 2'b00}
- mem_wdata  out  32  head lane-replicated data
- mem_wbe  out  4  head byte enables
- mem_ack  in  1  memory accepted the current head this cycle
- ld_addr  in  32  byte address of load in MEM stage
- ld_hit  out  1  combinational: some valid entry has word address == ld_addr[31:2]
- empty  out  1  count == 0
- count  out  CNT_W  current occupancy

## Operation
- Accept condition: st_valid && st_type != 00 && st_ready. A store that is not accepted is not captured. Upstream holds it and stalls.
- Alignment check on accept:
  - SH is misaligned if st_addr[0] = 1.
  - SW is misaligned if st_addr[1:0] != 00.
  - SB is never misaligned.
  - A misaligned store is not enqueued. misalign = 1 on the next cycle only.
- Lane formatting for an aligned store, with a = st_addr[1:0]:
  - SB: wbe = 4'b0001 << a; wdata = {4{st_data[7:0]}}.
  - SH: wbe = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - SW: wbe = 4'b1111; wdata = st_data.
- Each FIFO entry holds {word_addr[29:0], wdata[31:0], wbe[3:0]}. It uses circular write/read pointers of width log2(DEPTH) that wrap from DEPTH-1 to 0.
- Drain FSM has two states:
  - IDLE: empty, mem_req = 0. Go to ISSUE when count becomes nonzero.
  - ISSUE: mem_req = 1, and head fields are held stable until mem_ack.
  - On mem_ack the head pops. Go to IDLE if the buffer becomes empty, else stay in ISSUE and present the next head on the following cycle.
- mem_ack while mem_req = 0 is ignored.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Entries drain in strict FIFO order. There is no write combining or merging.
- ld_hit compares the full word address against every valid entry, regardless of wbe. It is 0 when empty.
- When mem_req = 0, mem_addr, mem_wdata and mem_wbe are driven to 0.
- Reset clears all state: pointers, count, FSM = IDLE, misalign = 0, mem_req = 0, mem_wbe = 0, empty = 1, count = 0. Entries are discarded and stores in flight are lost. Reset is asserted asynchronously and released synchronously to clk.

## Timing
- Enqueue to mem_req has 1 cycle latency: a store accepted at edge N gives mem_req = 1 after edge N.
- Each entry completes in at least one cycle. With ack held high, it sustains 1 store per cycle.
- st_ready falls the cycle after the DEPTH-th entry is written. It rises the cycle after the first pop from full.
- A pop in the same cycle does not free a slot for a push while full. st_ready depends on registered count only.
- misalign is valid the cycle after the offending accept cycle and lasts exactly 1 cycle.
- ld_hit and st_ready have no combinational path from st_valid. ld_hit depends only on ld_addr and the stored entries.

## Test plan
- Byte lanes:
  - Stimulus: SB to 0x103 with data 0x000000AB, mem_ack = 1.
  - Required: next cycle mem_req = 1, mem_addr = 0x100, mem_wbe = 1000, mem_wdata = 0xABABABAB.
  - Then the entry pops and empty = 1.
- Halfword and word:
  - Stimulus: SH to 0x202 with data 0x1234, then SW to 0x204 with data 0xDEADBEEF, mem_ack = 1.
  - Required: wbe = 1100 with wdata = 0x12341234, then wbe = 1111 with wdata = 0xDEADBEEF, in order.
- Misaligned:
  - Stimulus: SW to 0x301, then SH to 0x305.
  - Required: each produces a 1-cycle misalign pulse, count stays 0, mem_req never rises.
- Full/backpressure:
  - Stimulus: mem_ack = 0, push 5 SBs.
  - Required: after 4 pushes count = 4, st_ready = 0, and the 5th is not captured.
  - Then raise mem_ack for 1 cycle: count = 3 and st_ready = 1 next cycle. The pop order matches the push order and wraps correctly across pointer wrap.
- Load hazard:
  - Stimulus: buffer an SB to 0x40 with mem_ack = 0. ld_addr = 0x43 gives ld_hit = 1; ld_addr = 0x44 gives ld_hit = 0.
  - Required: after the ack drains the entry, ld_hit = 0 for 0x43.
- Reset mid-operation:
  - Stimulus: 3 entries queued with mem_req = 1, assert rst asynchronously between edges.
  - Required: mem_req = 0, count = 0, empty = 1 immediately. After release, the next SB gives a normal 1-cycle latency.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store request, load-hazard probe,
// the Data Memory drain handshake and occupancy status.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             st_valid;
  logic [1:0]       st_type;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_ready;
  logic             misalign;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wbe;
  logic             mem_ack;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic             empty;
  logic [CNT_W-1:0] count;

  // store buffer side
  modport slave (
    input  st_valid, st_type, st_addr, st_data, mem_ack, ld_addr,
    output st_ready, misalign, mem_req, mem_addr, mem_wdata, mem_wbe,
           ld_hit, empty, count
  );

  // pipeline / memory side
  modport master (
    output st_valid, st_type, st_addr, st_data, mem_ack, ld_addr,
    input  st_ready, misalign, mem_req, mem_addr, mem_wdata, mem_wbe,
           ld_hit, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW into word address + replicated data + byte
// enables, queues them in a circular FIFO and drains to Data Memory with a
// req/ack handshake. Flags misaligned stores and load-after-store hits.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic             mis_q, mis_d;

  entry_t     ent_d;
  logic       bad_align;
  logic       accept, push, pop, req;
  logic [1:0] a;

  // ready looks only at registered occupancy, so a same-cycle pop never
  // opens a slot while full
  assign sb.st_ready = (cnt_q < CNT_W'(DEPTH));
  assign accept      = sb.st_valid && (sb.st_type != 2'b00) && sb.st_ready;
  assign push        = accept && !bad_align;
  assign req         = (state_q == ISSUE);
  assign pop         = req && sb.mem_ack;
  assign a           = sb.st_addr[1:0];

  // lane formatting and alignment check of the incoming store
  always_comb begin
    ent_d       = '0;
    bad_align   = 1'b0;
    ent_d.waddr = sb.st_addr[31:2];
    unique case (sb.st_type)
      2'b01: begin
        ent_d.wbe   = 4'b0001 << a;
        ent_d.wdata = {4{sb.st_data[7:0]}};
      end
      2'b10: begin
        bad_align   = a[0];
        ent_d.wbe   = a[1] ? 4'b1100 : 4'b0011;
        ent_d.wdata = {2{sb.st_data[15:0]}};
      end
      2'b11: begin
        bad_align   = (a != 2'b00);
        ent_d.wbe   = 4'b1111;
        ent_d.wdata = sb.st_data;
      end
      default: ;
    endcase
  end

  // pointer, occupancy and per-slot valid next state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    mis_d = accept && bad_align;
    if (pop) begin
      rd_d        = rd_q + PTR_W'(1);
      vld_d[rd_q] = 1'b0;
    end
    if (push) begin
      wr_d        = wr_q + PTR_W'(1);
      vld_d[wr_q] = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // drain FSM next state: issue while anything is buffered
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cnt_d != '0) state_d = ISSUE;
      ISSUE:   if (pop && cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      mis_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
      state_q <= state_d;
    end
  end

  // entry storage; contents are meaningless unless the slot is valid
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_q] <= ent_d;
  end

  // load hazard: word-address match against any valid slot
  always_comb begin
    sb.ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && ent_q[i].waddr == sb.ld_addr[31:2]) sb.ld_hit = 1'b1;
  end

  assign sb.mem_req   = req;
  assign sb.mem_addr  = req ? {ent_q[rd_q].waddr, 2'b00} : 32'h0;
  assign sb.mem_wdata = req ? ent_q[rd_q].wdata : 32'h0;
  assign sb.mem_wbe   = req ? ent_q[rd_q].wbe : 4'h0;
  assign sb.misalign  = mis_q;
  assign sb.empty     = (cnt_q == '0);
  assign sb.count     = cnt_q;
endmodule
